// File: rtl/instr_encoder.sv
// RV32I instruction word packer: immediate + register/opcode fields -> 32-bit word,
// with LI expansion into ADDI or LUI(+ADDI) behind a registered valid/ready stage.
module instr_encoder #(
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [K-1:0] in_fmt_i,
  input  logic [6:0]   in_opcode_i,
  input  logic [2:0]   in_funct3_i,
  input  logic [4:0]   in_rd_i,
  input  logic [4:0]   in_rs1_i,
  input  logic [4:0]   in_rs2_i,
  input  logic [31:0]  in_imm_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_instr_o,
  output logic         out_err_o,
  output logic         out_last_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_PAIR  = 2'd2
  } state_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {hi, rd, op};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] held_q, held_d;

  logic [2:0]         fmt_s;
  logic signed [31:0] imm_sg_s;
  logic [31:0]        li_sum_s;
  logic               in12_s, b_ok_s, j_ok_s;
  logic [31:0]        enc_word_s, enc_held_s;
  logic               enc_err_s, enc_pair_s;
  logic               accept_s;

  assign fmt_s    = in_fmt_i[2:0];
  assign imm_sg_s = $signed(in_imm_i);
  // LUI must absorb the sign of the low 12 bits that ADDI will sign-extend back in.
  assign li_sum_s = in_imm_i + 32'h0000_0800;
  assign in12_s   = (imm_sg_s >= -32'sd2048) && (imm_sg_s <= 32'sd2047);
  assign b_ok_s   = (imm_sg_s >= -32'sd4096) && (imm_sg_s <= 32'sd4094) && !in_imm_i[0];
  assign j_ok_s   = (imm_sg_s >= -32'sd1048576) && (imm_sg_s <= 32'sd1048574) && !in_imm_i[0];

  // Field packing and range check for the request currently on the inputs.
  always_comb begin
    enc_word_s = 32'd0;
    enc_held_s = 32'd0;
    enc_err_s  = 1'b0;
    enc_pair_s = 1'b0;
    case (fmt_s)
      3'b000: begin
        enc_word_s = enc_i(in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i);
        enc_err_s  = !in12_s;
      end
      3'b001: begin
        enc_word_s = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], in_opcode_i};
        enc_err_s  = !in12_s;
      end
      3'b010: begin
        enc_word_s = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                      in_imm_i[4:1], in_imm_i[11], in_opcode_i};
        enc_err_s  = !b_ok_s;
      end
      3'b011: begin
        enc_word_s = enc_u(in_imm_i[31:12], in_rd_i, in_opcode_i);
        enc_err_s  = (in_imm_i[11:0] != 12'd0);
      end
      3'b100: begin
        enc_word_s = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12], in_rd_i, in_opcode_i};
        enc_err_s  = !j_ok_s;
      end
      3'b101: begin
        enc_word_s = enc_u(in_imm_i[31:12], in_rd_i, OP_LUI);
        enc_err_s  = (in_imm_i[11:0] != 12'd0);
      end
      3'b110: begin
        if (in12_s) begin
          enc_word_s = enc_i(in_imm_i[11:0], 5'd0, 3'b000, in_rd_i, OP_IMM);
        end else begin
          enc_word_s = enc_u(li_sum_s[31:12], in_rd_i, OP_LUI);
          enc_held_s = enc_i(in_imm_i[11:0], in_rd_i, 3'b000, in_rd_i, OP_IMM);
          enc_pair_s = (in_imm_i[11:0] != 12'd0);
        end
      end
      default: begin
        enc_word_s = 32'd0;
        enc_err_s  = 1'b1;
      end
    endcase
  end

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = (state_q != ST_PAIR) && (!out_valid_o || out_ready_i);
  assign accept_s    = in_valid_i && in_ready_o;

  // Output-stage next state: load, pop, or release the held ADDI of a split LI.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    last_d  = last_q;
    held_d  = held_q;
    case (state_q)
      ST_EMPTY, ST_FULL: begin
        if (accept_s) begin
          instr_d = enc_word_s;
          err_d   = enc_err_s;
          last_d  = !enc_pair_s;
          held_d  = enc_held_s;
          state_d = enc_pair_s ? ST_PAIR : ST_FULL;
        end else if (out_valid_o && out_ready_i) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = state_q;
        end
      end
      ST_PAIR: begin
        if (out_ready_i) begin
          instr_d = held_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_PAIR;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Output stage and held second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      held_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      held_q  <= held_d;
    end
  end

  assign out_instr_o = instr_q;
  assign out_err_o   = err_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed handshake sequences,
// and randomized traffic against an arithmetic reference model with a word scoreboard.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err, out_last;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  exp_t sb[$];
  bit   stall_prev = 1'b0;
  exp_t prev_out;

  instr_encoder #(.K(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_fmt_i(in_fmt), .in_opcode_i(in_opcode), .in_funct3_i(in_funct3),
    .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_imm_i(in_imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_err_o(out_err), .out_last_o(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mv(input req_t r, input logic [31:0] instr, input logic err);
    vec_t v;
    v.r = r; v.e.instr = instr; v.e.err = err; v.e.last = 1'b1;
    return v;
  endfunction

  // Reference model: fields placed by weighting with powers of two, ranges checked as integers.
  function automatic void model(input req_t r, output int n, output exp_t e0, output exp_t e1);
    bit [31:0] u, op, f3, rd, rs1, rs2, t, lo;
    longint s;
    u = r.imm; op = r.op; f3 = r.f3; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
    s = longint'($signed(r.imm));
    n = 1;
    e0.instr = 32'd0; e0.err = 1'b0; e0.last = 1'b1;
    e1.instr = 32'd0; e1.err = 1'b0; e1.last = 1'b1;
    case (r.fmt)
      3'd0: begin
        e0.instr = (u % 4096) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
        e0.err   = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        e0.instr = ((u / 32) % 128) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
                   + (u % 32) * 128 + op;
        e0.err   = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        e0.instr = ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432 + rs2 * 1048576
                   + rs1 * 32768 + f3 * 4096 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + op;
        e0.err   = (s < -4096) || (s > 4094) || (u % 2 != 0);
      end
      3'd3: begin
        e0.instr = (u / 4096) * 4096 + rd * 128 + op;
        e0.err   = (u % 4096 != 0);
      end
      3'd4: begin
        e0.instr = ((u / 1048576) % 2) * 32'h8000_0000 + ((u / 2) % 1024) * 2097152
                   + ((u / 2048) % 2) * 1048576 + ((u / 4096) % 256) * 4096 + rd * 128 + op;
        e0.err   = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
      end
      3'd5: begin
        e0.instr = (u / 4096) * 4096 + rd * 128 + 55;
        e0.err   = (u % 4096 != 0);
      end
      3'd6: begin
        if (s >= -2048 && s <= 2047) begin
          e0.instr = (u % 4096) * 1048576 + rd * 128 + 19;
        end else begin
          t  = u + 32'h800;
          lo = u % 4096;
          e0.instr = (t / 4096) * 4096 + rd * 128 + 55;
          if (lo != 0) begin
            n = 2;
            e0.last  = 1'b0;
            e1.instr = lo * 1048576 + rd * 32768 + rd * 128 + 19;
          end
        end
      end
      default: begin
        e0.instr = 32'd0;
        e0.err   = 1'b1;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r, input bit v);
    in_valid = v; in_fmt = r.fmt; in_opcode = r.op; in_funct3 = r.f3;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, e.instr);
    chk({tag, ".err"}, {31'd0, out_err}, {31'd0, e.err});
    chk({tag, ".last"}, {31'd0, out_last}, {31'd0, e.last});
  endtask

  // One scoreboarded cycle: drive, sample mid-cycle, pop/push the expected-word queue.
  task automatic cyc(input req_t r, input bit v, input bit rdy, output bit acc, output bit ir);
    exp_t e0, e1, got;
    int n;
    drive(r, v);
    out_ready = rdy;
    @(negedge clk);
    ir  = in_ready;
    acc = in_valid && in_ready;
    if (stall_prev) begin
      got.instr = out_instr; got.err = out_err; got.last = out_last;
      chk("hold.instr", got.instr, prev_out.instr);
      chk("hold.flags", {30'd0, got.err, got.last}, {30'd0, prev_out.err, prev_out.last});
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_word", out_instr, 32'hDEAD_BEEF);
      end else begin
        e0 = sb.pop_front();
        n_pop++;
        chk_out("sb", e0);
      end
    end
    if (acc) begin
      model(r, n, e0, e1);
      sb.push_back(e0);
      if (n == 2) sb.push_back(e1);
    end
    stall_prev = out_valid && !out_ready;
    prev_out.instr = out_instr; prev_out.err = out_err; prev_out.last = out_last;
    tick();
  endtask

  task automatic drain();
    bit acc, ir;
    req_t idle;
    idle = mk(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cyc(idle, 1'b0, 1'b1, acc, ir);
    chk("drain.sb_empty", sb.size(), 32'd0);
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_imm();
    int bnd[15] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    1048574, 1048575, 1048576, -1048576, -1048578, 0};
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($signed($urandom_range(0, 8191)) - 4096);
      2: return 32'(bnd[$urandom_range(0, 14)]);
      default: return ($urandom() & 32'hFFFF_F000) | (($urandom_range(0, 1) == 1) ? 32'h0 : 32'h123);
    endcase
  endfunction

  function automatic req_t rnd_req();
    return mk(3'($urandom_range(0, 7)), 7'($urandom()), 3'($urandom()), 5'($urandom()),
              5'($urandom()), 5'($urandom()), rnd_imm());
  endfunction

  initial begin
    vec_t vt[16];
    req_t idle, r, li;
    bit acc, ir;
    idle = mk(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    vt[0]  = mv(mk(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF), 32'hFFF3_0293, 1'b0);
    vt[1]  = mv(mk(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_F800), 32'h8003_0293, 1'b0);
    vt[2]  = mv(mk(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'h0000_0800), 32'h8003_0293, 1'b1);
    vt[3]  = mv(mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000), 32'h8020_8063, 1'b0);
    vt[4]  = mv(mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_1000), 32'h8020_8063, 1'b1);
    vt[5]  = mv(mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0003), 32'h0020_8163, 1'b1);
    vt[6]  = mv(mk(3'd7, 7'h63, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0000_0010), 32'h0000_0000, 1'b1);
    vt[7]  = mv(mk(3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'h0000_07FF), 32'h7E31_2FA3, 1'b0);
    vt[8]  = mv(mk(3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'h0000_0800), 32'h8031_2023, 1'b1);
    vt[9]  = mv(mk(3'd3, 7'h17, 3'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_5197, 1'b0);
    vt[10] = mv(mk(3'd3, 7'h17, 3'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5001), 32'h1234_5197, 1'b1);
    vt[11] = mv(mk(3'd5, 7'h00, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000), 32'hABCD_E3B7, 1'b0);
    vt[12] = mv(mk(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800), 32'h0010_00EF, 1'b0);
    vt[13] = mv(mk(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE), 32'hFFFF_F0EF, 1'b0);
    vt[14] = mv(mk(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000), 32'h8000_00EF, 1'b1);
    vt[15] = mv(mk(3'd6, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0001_0000), 32'h0001_00B7, 1'b0);

    rst_n = 1'b0; out_ready = 1'b0;
    drive(idle, 1'b0);
    #12;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.out_instr", out_instr, 32'd0);
    chk("reset.out_err_last", {30'd0, out_err, out_last}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-word vectors, one request every two cycles.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].r, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("vec.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(idle, 1'b0);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vt[i].e);
      tick();
    end
    @(negedge clk);
    chk("vec.drained", {31'd0, out_valid}, 32'd0);
    tick();

    // Two-word LI held by back-pressure on each word.
    li = mk(3'd6, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    drive(li, 1'b1);
    out_ready = 1'b0;
    tick();
    drive(idle, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("li2.lui", '{32'h1234_5537, 1'b0, 1'b0});
      chk("li2.in_ready_pair", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("li2.in_ready_pop", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("li2.addi", '{32'h6785_0513, 1'b0, 1'b1});
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("li2.empty", {31'd0, out_valid}, 32'd0);
    tick();

    // LI whose low half forces a carry into the LUI.
    drive(mk(3'd6, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800), 1'b1);
    tick();
    drive(idle, 1'b0);
    @(negedge clk);
    chk_out("li3.lui", '{32'h0000_10B7, 1'b0, 1'b0});
    tick();
    @(negedge clk);
    chk_out("li3.addi", '{32'h8000_8093, 1'b0, 1'b1});
    tick();
    @(negedge clk);
    chk("li3.empty", {31'd0, out_valid}, 32'd0);
    tick();

    // Back-to-back stream, then a stall with a pending request.
    stall_prev = 1'b0;
    n_pop = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(mk(3'd0, 7'h13, 3'd0, 5'(i + 1), 5'd2, 5'd0, 32'(i + 1)), 1'b1, 1'b1, acc, ir);
      chk("stream.accept", {31'd0, acc}, 32'd1);
    end
    r = mk(3'd0, 7'h13, 3'd1, 5'd9, 5'd4, 5'd0, 32'd77);
    cyc(r, 1'b1, 1'b0, acc, ir);
    chk("stall.in_ready", {31'd0, ir}, 32'd0);
    cyc(r, 1'b1, 1'b0, acc, ir);
    chk("stall.in_ready2", {31'd0, ir}, 32'd0);
    cyc(r, 1'b1, 1'b1, acc, ir);
    chk("resume.accept", {31'd0, acc}, 32'd1);
    drain();
    chk("stream.count", n_pop, 32'd5);

    // Randomized traffic.
    r = rnd_req();
    for (int i = 0; i < 1500; i++) begin
      cyc(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), acc, ir);
      if (acc) r = rnd_req();
    end
    drain();

    // Asynchronous reset while the ADDI half of an LI is held.
    drive(li, 1'b1);
    out_ready = 1'b0;
    tick();
    drive(idle, 1'b0);
    @(negedge clk);
    chk("arst.pre_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.out_instr", out_instr, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst.no_addi", {31'd0, out_valid}, 32'd0);
      chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
